// File: rtl/tiny_dnn_pkg.sv
// Shared types for the tiny_dnn source framer: FSM states and the tagged word carried by the FIFO.
package tiny_dnn_pkg;

  localparam int FR_DEPTH = 16;
  localparam int FR_AW    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } framer_state_t;

  typedef struct {
    real  d;
    logic last;
  } src_word_t;

endpackage

// File: rtl/tiny_dnn_sfifo.sv
// Synchronous FIFO of tagged words; wrapping AW+1-bit pointers give occupancy directly.
module tiny_dnn_sfifo
  import tiny_dnn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  src_word_t     wr_word,
  output src_word_t     rd_word,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  src_word_t   mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp[AW-1:0]] <= wr_word;
  end

  assign rd_word = mem[rp[AW-1:0]];
  assign level   = wp - rp;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wp == rp);

endmodule

// File: rtl/tiny_dnn_src_framer.sv
// Frames an unframed host word stream into samples of (ss+1) words for tiny_dnn_top's src port.
// state | meaning
// IDLE  | waiting for start, FIFO empty
// RUN   | accepting host words and draining to src until the batch's final word pops
// FIN   | one cycle with done=1, then back to IDLE
module tiny_dnn_src_framer
  import tiny_dnn_pkg::*;
#(
  parameter int DEPTH = FR_DEPTH,
  parameter int AW    = FR_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [11:0]   ss,
  input  logic [9:0]    nsmp,
  input  logic          in_valid,
  input  real           in_data,
  output logic          in_ready,
  output logic          src_valid,
  output real           src_data,
  output logic          src_last,
  input  logic          src_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   level
);

  framer_state_t state, state_nxt;
  logic [11:0]   ss_l;
  logic [9:0]    nsmp_l;
  logic [11:0]   wc;
  logic [9:0]    sc;
  logic [9:0]    out_sc;
  logic          acc_done;
  logic          full, empty, push, pop, last_in;
  src_word_t     wr_word, rd_word;

  assign in_ready  = (state == RUN) && !full && !acc_done;
  assign src_valid = !empty;
  assign src_data  = empty ? 0.0 : rd_word.d;
  assign src_last  = !empty && rd_word.last;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  assign push    = in_valid && in_ready && !abort;
  assign pop     = src_valid && src_ready && !abort;
  assign last_in = (wc == ss_l);

  assign wr_word.d    = in_data;
  assign wr_word.last = last_in;

  tiny_dnn_sfifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .push    (push),
    .pop     (pop),
    .wr_word (wr_word),
    .rd_word (rd_word),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (pop && src_last && (out_sc == nsmp_l)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_l     <= '0;
      nsmp_l   <= '0;
      wc       <= '0;
      sc       <= '0;
      out_sc   <= '0;
      acc_done <= 1'b0;
    end else if (abort) begin
      wc       <= '0;
      sc       <= '0;
      out_sc   <= '0;
      acc_done <= 1'b0;
    end else if (state == IDLE && start) begin
      ss_l     <= ss;
      nsmp_l   <= nsmp;
      wc       <= '0;
      sc       <= '0;
      out_sc   <= '0;
      acc_done <= 1'b0;
    end else begin
      if (push) begin
        if (last_in) begin
          wc <= '0;
          sc <= sc + 1'b1;
          // Final word of the batch closes acceptance for the rest of the run.
          if (sc == nsmp_l) acc_done <= 1'b1;
        end else begin
          wc <= wc + 1'b1;
        end
      end
      if (pop && src_last) out_sc <= out_sc + 1'b1;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_src_framer.sv
// Directed scoreboard bench for tiny_dnn_src_framer: expected words queued at issue, checked on src handshakes.
module tb_tiny_dnn_src_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] ss = '0;
  logic [9:0]  nsmp = '0;
  logic        in_valid = 1'b0;
  real         in_data = 0.0;
  logic        in_ready;
  logic        src_valid;
  real         src_data;
  logic        src_last;
  logic        src_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  level;

  int   n_cmp = 0;
  int   n_err = 0;
  real  qd[$];
  bit   ql[$];
  int   cyc = 0;
  int   last_pop_cyc = -1;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   max_level = 0;

  tiny_dnn_src_framer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ss(ss), .nsmp(nsmp),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(level) > max_level) max_level = int'(level);
  end

  // Monitor: every src handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !abort && src_valid && src_ready) begin
      n_cmp++;
      last_pop_cyc = cyc;
      if (qd.size() == 0) begin
        n_err++;
        $display("FAIL src_unexpected: got data=%0.1f last=%0b, required no beat", src_data, src_last);
      end else begin
        if (src_data != qd[0] || src_last != ql[0]) begin
          n_err++;
          $display("FAIL src_beat: got data=%0.1f last=%0b, required data=%0.1f last=%0b",
                   src_data, src_last, qd[0], ql[0]);
        end
        void'(qd.pop_front());
        void'(ql.pop_front());
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_r(string nm, real act, real exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0.3f, required %0.3f", nm, act, exp);
    end
  endtask

  task automatic expect_batch(real base, int n, int spw);
    for (int i = 0; i < n; i++) begin
      qd.push_back(base + real'(i));
      ql.push_back((i % spw) == (spw - 1));
    end
  endtask

  task automatic do_start(int s, int n);
    @(posedge clk); #1;
    start = 1'b1; ss = 12'(s); nsmp = 10'(n);
    @(posedge clk); #1;
    start = 1'b0; ss = 12'hfff; nsmp = 10'h3ff;
  endtask

  task automatic send(real v);
    int t = 0;
    in_valid = 1'b1; in_data = v;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: word %0.1f not accepted within 300 cycles, in_ready=%0b", v, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(string nm, int bound);
    int t = 0;
    @(negedge clk);
    while (busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk(nm, int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_in_ready"},  int'(in_ready), 0);
    chk({tag, "_src_valid"}, int'(src_valid), 0);
    chk({tag, "_src_last"},  int'(src_last), 0);
    chk_r({tag, "_src_data"}, src_data, 0.0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_level"},     int'(level), 0);
  endtask

  initial begin
    int hi_cnt;
    int drain_t;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ss=3, nsmp=1, 8 words with free-running consumer
    src_ready = 1'b1;
    done_cnt = 0;
    expect_batch(1.0, 8, 4);
    do_start(3, 1);
    for (int i = 0; i < 8; i++) send(1.0 + real'(i));
    @(negedge clk);
    chk("t1_in_ready_after_last", int'(in_ready), 0);
    wait_idle("t1_idle", 50);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_timing", done_cyc, last_pop_cyc + 1);
    chk("t1_sb_empty", qd.size(), 0);

    // 2: backpressure fills the FIFO, then drains in order
    src_ready = 1'b0;
    done_cnt = 0;
    expect_batch(11.0, 20, 5);
    do_start(4, 3);
    fork
      for (int i = 0; i < 20; i++) send(11.0 + real'(i));
      begin
        repeat (30) @(negedge clk);
        chk("t2_level_sat", int'(level), 16);
        chk("t2_in_ready_full", int'(in_ready), 0);
        @(posedge clk); #1;
        src_ready = 1'b1;
      end
    join
    wait_idle("t2_idle", 100);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_sb_empty", qd.size(), 0);

    // 3: single-word samples; a fourth host word is never accepted
    done_cnt = 0;
    expect_batch(101.0, 3, 1);
    do_start(0, 2);
    for (int i = 0; i < 3; i++) send(101.0 + real'(i));
    in_valid = 1'b1; in_data = 104.0;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) hi_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_extra_refused", hi_cnt, 0);
    wait_idle("t3_idle", 50);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_sb_empty", qd.size(), 0);

    // 4: 1000 words, random valid/ready after priming level to 5
    done_cnt = 0;
    max_level = 0;
    src_ready = 1'b0;
    expect_batch(1000.0, 1000, 10);
    do_start(9, 99);
    for (int i = 0; i < 5; i++) send(1000.0 + real'(i));
    @(negedge clk);
    chk("t4_level_primed", int'(level), 5);
    @(posedge clk); #1;
    fork
      for (int i = 5; i < 1000; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send(1000.0 + real'(i));
      end
      begin
        drain_t = 0;
        while (busy && drain_t < 20000) begin
          @(posedge clk); #1;
          src_ready = ($urandom_range(0, 1) == 1);
          drain_t++;
        end
        src_ready = 1'b1;
      end
    join
    wait_idle("t4_idle", 100);
    chk("t4_max_level_le16", int'(max_level <= 16), 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_sb_empty", qd.size(), 0);

    // 5: abort at level 7, then a clean run
    done_cnt = 0;
    src_ready = 1'b0;
    do_start(7, 3);
    for (int i = 0; i < 7; i++) send(50.0 + real'(i));
    @(negedge clk);
    chk("t5_level_pre_abort", int'(level), 7);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_level_post", int'(level), 0);
    chk("t5_src_valid_post", int'(src_valid), 0);
    chk("t5_busy_post", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    src_ready = 1'b1;
    expect_batch(201.0, 2, 2);
    do_start(1, 0);
    for (int i = 0; i < 2; i++) send(201.0 + real'(i));
    wait_idle("t5_idle", 50);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_sb_empty", qd.size(), 0);

    // 6: async reset mid-run, start ignored while busy, start+abort together
    src_ready = 1'b0;
    done_cnt = 0;
    do_start(3, 3);
    for (int i = 0; i < 3; i++) send(70.0 + real'(i));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_no_done", done_cnt, 0);

    src_ready = 1'b1;
    expect_batch(301.0, 4, 2);
    do_start(1, 1);
    for (int i = 0; i < 2; i++) send(301.0 + real'(i));
    start = 1'b1; ss = 12'd0; nsmp = 10'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i < 4; i++) send(301.0 + real'(i));
    wait_idle("t6_idle", 50);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_sb_empty", qd.size(), 0);

    start = 1'b1; abort = 1'b1; ss = 12'd1; nsmp = 10'd0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t6_start_abort_busy", int'(busy), 0);
    chk("t6_start_abort_ready", int'(in_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
